tdec_wrap_crc_engine: RTL

Framed, parametrised CRC engine for the turbo-decoder wrapper. It accepts a byte- or word-wide data stream with start/end-of-frame markers and computes one of four runtime-selected LTE CRCs: CRC8, CRC16, CRC24A or CRC24B. In generate mode it reports the CRC. In check mode it reports whether the frame, including its appended CRC, leaves a zero remainder. It replaces the fixed CRC8 combinational calculators and sits between the decoder output buffer and the code-block/transport-block status logic.

---
 rtl/tdec_crc_pkg.sv | 20 ++
 rtl/tdec_crc_step.sv | 20 ++
 rtl/tdec_wrap_crc_engine.sv | 89 ++++++++
 3 files changed

// File: rtl/tdec_crc_pkg.sv
// tdec_crc_pkg: polynomial constants, widths, select and FSM encodings for the CRC engine
package tdec_crc_pkg;
    typedef enum logic [1:0] {SEL_CRC8, SEL_CRC16, SEL_CRC24A, SEL_CRC24B} poly_sel_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    localparam int PW_W = 6;
    localparam logic [23:0] POLY_CRC8   = 24'h00009B;
    localparam logic [23:0] POLY_CRC16  = 24'h001021;
    localparam logic [23:0] POLY_CRC24A = 24'h864CFB;
    localparam logic [23:0] POLY_CRC24B = 24'h800063;
    localparam logic [PW_W-1:0] W_CRC8  = 6'd8;
    localparam logic [PW_W-1:0] W_CRC16 = 6'd16;
    localparam logic [PW_W-1:0] W_CRC24 = 6'd24;
    function automatic logic [23:0] poly_of(input poly_sel_e s);
        return s == SEL_CRC8 ? POLY_CRC8 : s == SEL_CRC16 ? POLY_CRC16 :
               s == SEL_CRC24A ? POLY_CRC24A : POLY_CRC24B;
    endfunction
    function automatic logic [PW_W-1:0] width_of(input poly_sel_e s);
        return s == SEL_CRC8 ? W_CRC8 : s == SEL_CRC16 ? W_CRC16 : W_CRC24;
    endfunction
endpackage

// File: rtl/tdec_crc_step.sv
// tdec_crc_step: combinational DATA_W-bit parallel CRC update in a top-aligned register
module tdec_crc_step import tdec_crc_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 24
) (
    input  logic [CRC_W-1:0]  ci,
    input  logic [DATA_W-1:0] di,
    input  logic [CRC_W-1:0]  poly,
    input  logic [PW_W-1:0]   pw,
    output logic [CRC_W-1:0]  co
);
    logic [CRC_W-1:0] pa;
    // unrolled MSB-first shift/xor; narrower polynomials are shifted to the top of the register
    always_comb begin
        pa = poly << (PW_W'(CRC_W) - pw);
        co = ci;
        for (int i = DATA_W - 1; i >= 0; i--)
            co = {co[CRC_W-2:0], 1'b0} ^ ((co[CRC_W-1] ^ di[i]) ? pa : '0);
    end
endmodule

// File: rtl/tdec_wrap_crc_engine.sv
// tdec_wrap_crc_engine: framed LTE CRC8/16/24A/24B engine; check mode built only with TDEC_CRC_CHK_EN
module tdec_wrap_crc_engine import tdec_crc_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_poly_sel,
    input  logic              cfg_chk,
    input  logic              din_vld,
    output logic              din_rdy,
    input  logic [DATA_W-1:0] din,
    input  logic              din_sop,
    input  logic              din_eop,
    output logic              crc_vld,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic              err_sop,
    output logic              err_nosop
);
    state_e           state, state_d;
    poly_sel_e        sel_q, sel_use;
    logic [CRC_W-1:0] crc_reg, step_in, step_out, poly_use;
    logic [PW_W-1:0]  pw_use;
    logic             acc, upd;

    assign din_rdy  = !rst && state != S_DONE;
    assign acc      = din_vld && din_rdy;
    assign upd      = acc && (din_sop || state == S_RUN);
    assign sel_use  = din_sop ? poly_sel_e'(cfg_poly_sel) : sel_q;
    assign poly_use = CRC_W'(poly_of(sel_use));
    assign pw_use   = width_of(sel_use);
    assign step_in  = din_sop ? '0 : crc_reg;

    tdec_crc_step #(.DATA_W(DATA_W), .CRC_W(CRC_W)) u_step (
        .ci(step_in), .di(din), .poly(poly_use), .pw(pw_use), .co(step_out)
    );

    // next state: a frame opens on SOP, closes on EOP, and DONE is a single bubble
    always_comb begin
        state_d = state == S_DONE ? S_IDLE : upd ? (din_eop ? S_DONE : S_RUN) : state;
    end

    // state, running remainder and latched polynomial
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            crc_reg <= '0;
            sel_q   <= SEL_CRC8;
        end else begin
            state <= state_d;
            if (upd) crc_reg <= step_out;
            if (acc && din_sop) sel_q <= sel_use;
        end
    end

    // result strobe, right-aligned result and framing error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_vld   <= 1'b0;
            crc_out   <= '0;
            err_sop   <= 1'b0;
            err_nosop <= 1'b0;
        end else begin
            crc_vld   <= state_d == S_DONE;
            err_sop   <= acc && din_sop && state == S_RUN;
            err_nosop <= acc && !din_sop && state == S_IDLE;
            if (state_d == S_DONE) crc_out <= step_out >> (PW_W'(CRC_W) - pw_use);
        end
    end

`ifdef TDEC_CRC_CHK_EN
    logic chk_q;
    // latched check mode and zero-remainder verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_q  <= 1'b0;
            crc_ok <= 1'b0;
        end else begin
            if (acc && din_sop) chk_q <= cfg_chk;
            if (state_d == S_DONE) crc_ok <= (din_sop ? cfg_chk : chk_q) && step_out == '0;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = cfg_chk;
    assign crc_ok     = 1'b0;
`endif
endmodule
